pwm_multi_channel: RTL

- N-channel PWM generator: one shared prescaler and one shared period counter, with a per-channel compare against a double-buffered duty value.
- Supports edge-aligned or center-aligned mode, per-channel output polarity, glitch-free duty update at the period boundary, and true 0 % / 100 % duty.
- Sits between the register/control logic and the motor or LED driver pins.

---
 rtl/pwm_pkg.sv | 8 +
 rtl/pwm_prescaler.sv | 22 ++
 rtl/pwm_multi_channel.sv | 106 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode encodings and duty-slice indexing for the PWM block
package pwm_pkg;
   localparam logic MODE_EDGE   = 1'b0;
   localparam logic MODE_CENTER = 1'b1;
   function automatic int duty_lsb(input int k, input int counter_bits);
      return k * (counter_bits + 1);
   endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk into one tick every final_value+1 clocks
module pwm_prescaler #(
   parameter int TIMER_BITS = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [TIMER_BITS-1:0] final_value,
   output logic                  tick
);
   logic [TIMER_BITS-1:0] cnt_q, cnt_d;
   // a lowered terminal count below the current value is only met after the count wraps
   always_comb begin
      tick  = enable && (cnt_q == final_value);
      cnt_d = (!enable || tick) ? '0 : cnt_q + 1'b1;
   end
   // prescaler count register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
endmodule

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: N-channel PWM with shared edge/center counter and shadowed duties
module pwm_multi_channel
   import pwm_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int COUNTER_BITS = 8,
   parameter int TIMER_BITS   = 16
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 enable,
   input  logic [TIMER_BITS-1:0]                final_value,
   input  logic                                 center_mode,
   input  logic [CHANNELS*(COUNTER_BITS+1)-1:0] duty_cycle,
   input  logic [CHANNELS-1:0]                  duty_load,
   input  logic [CHANNELS-1:0]                  polarity,
   output logic [CHANNELS-1:0]                  pwm_out,
   output logic                                 period_start
);
   localparam int DW = COUNTER_BITS + 1;
   localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;
   localparam logic [COUNTER_BITS-1:0] CNT_ONE = 1;

   logic                    tick, bnd;
   logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
   logic                    dir_down_q, dir_down_d;
   logic                    mode_q, mode_d;
   logic                    period_start_q, period_start_d;
   logic [CHANNELS-1:0]     raw, pwm_q, pwm_d;

   pwm_prescaler #(.TIMER_BITS(TIMER_BITS)) u_prescaler (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .final_value (final_value),
      .tick        (tick)
   );

   // counter walk; bnd flags the tick that lands on 0 by wrap or by down-count
   always_comb begin
      cnt_d      = cnt_q;
      dir_down_d = dir_down_q;
      bnd        = 1'b0;
      if (!enable) begin
         cnt_d      = '0;
         dir_down_d = 1'b0;
      end else if (tick) begin
         if (mode_q == MODE_EDGE) begin
            cnt_d      = cnt_q + 1'b1;
            dir_down_d = 1'b0;
            bnd        = (cnt_q == CNT_MAX);
         end else if (!dir_down_q) begin
            cnt_d      = (cnt_q == CNT_MAX) ? cnt_q - 1'b1 : cnt_q + 1'b1;
            dir_down_d = (cnt_q == CNT_MAX);
         end else begin
            cnt_d      = cnt_q - 1'b1;
            bnd        = (cnt_q == CNT_ONE);
            dir_down_d = (cnt_q != CNT_ONE);
         end
      end
      mode_d         = (!enable || bnd) ? center_mode : mode_q;
      period_start_d = bnd;
      pwm_d          = enable ? (raw ^ polarity) : polarity;
   end

   // shared counter, mode shadow and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q          <= '0;
         dir_down_q     <= 1'b0;
         mode_q         <= MODE_EDGE;
         period_start_q <= 1'b0;
         pwm_q          <= '0;
      end else begin
         cnt_q          <= cnt_d;
         dir_down_q     <= dir_down_d;
         mode_q         <= mode_d;
         period_start_q <= period_start_d;
         pwm_q          <= pwm_d;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      localparam int LSB = duty_lsb(k, COUNTER_BITS);
      logic [DW-1:0] pend_q, pend_d, act_q, act_d;
      // a load on the boundary (or while idle) goes straight through to the active duty
      always_comb begin
         pend_d = duty_load[k] ? duty_cycle[LSB +: DW] : pend_q;
         act_d  = (!enable || bnd) ? pend_d : act_q;
      end
      // pending and active duty registers
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            pend_q <= '0;
            act_q  <= '0;
         end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
         end
      end
      assign raw[k] = {1'b0, cnt_q} < act_q;
   end

   assign pwm_out      = pwm_q;
   assign period_start = period_start_q;
endmodule
